// File: rtl/hv_reg_access_arb_nch.sv
// hv_reg_access_arb_nch: N-requester register-access arbiter.
// Fixed or round-robin grant, one bank strobe per access, ack timeout.
module hv_reg_access_arb_nch #(
    parameter int REQ_NUM   = 4,
    parameter int REG_AW    = 7,
    parameter int REG_DW    = 8,
    parameter int REG_CRC_W = 8,
    parameter int TMO_CYC   = 15,
    parameter int GID_W     = $clog2(REQ_NUM)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [REQ_NUM-1:0]           i_req_vld,
    input  logic [REQ_NUM-1:0]           i_req_wr,
    input  logic [REQ_NUM*REG_AW-1:0]    i_req_addr,
    input  logic [REQ_NUM*REG_DW-1:0]    i_req_wdata,
    input  logic [REQ_NUM*REG_CRC_W-1:0] i_req_wcrc,
    input  logic                         i_rr_en,
    input  logic                         i_tmo_cnt_clr,
    output logic [REQ_NUM-1:0]           o_req_ack,
    output logic [REQ_NUM-1:0]           o_req_err,
    output logic [REG_DW-1:0]            o_rsp_rdata,
    output logic [REG_CRC_W-1:0]         o_rsp_rcrc,
    output logic [REG_AW-1:0]            o_rsp_addr,
    output logic                         o_busy,
    output logic [7:0]                   o_tmo_cnt,
    output logic                         o_rac_reg_ren,
    output logic                         o_rac_reg_wen,
    output logic [REG_AW-1:0]            o_rac_reg_addr,
    output logic [REG_DW-1:0]            o_rac_reg_wdata,
    output logic [REG_CRC_W-1:0]         o_rac_reg_wcrc,
    input  logic                         i_reg_rac_wack,
    input  logic                         i_reg_rac_rack,
    input  logic [REG_DW-1:0]            i_reg_rac_rdata,
    input  logic [REG_CRC_W-1:0]         i_reg_rac_rcrc
);

    localparam int TW = $clog2(TMO_CYC) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               r_state;
    logic [GID_W-1:0]     r_ptr;
    logic [GID_W-1:0]     r_gid;
    logic                 r_wr;
    logic [TW-1:0]        r_tmr;
    logic [REQ_NUM-1:0]   r_req_ack;
    logic [REQ_NUM-1:0]   r_req_err;
    logic [REG_DW-1:0]    r_rsp_rdata;
    logic [REG_CRC_W-1:0] r_rsp_rcrc;
    logic [REG_AW-1:0]    r_rsp_addr;
    logic                 r_busy;
    logic [7:0]           r_tmo_cnt;
    logic                 r_ren;
    logic                 r_wen;
    logic [REG_AW-1:0]    r_rac_addr;
    logic [REG_DW-1:0]    r_rac_wdata;
    logic [REG_CRC_W-1:0] r_rac_wcrc;

    logic [REG_AW-1:0]    w_addr  [REQ_NUM];
    logic [REG_DW-1:0]    w_wdata [REQ_NUM];
    logic [REG_CRC_W-1:0] w_wcrc  [REQ_NUM];
    logic                 w_hit;
    logic [GID_W-1:0]     w_gid;
    logic [GID_W:0]       w_idx;
    logic [REQ_NUM-1:0]   w_gid_oh;
    logic                 w_ack_ok;
    logic                 w_tmo;

    for (genvar g = 0; g < REQ_NUM; g++) begin : g_slice
        assign w_addr[g]  = i_req_addr[g*REG_AW +: REG_AW];
        assign w_wdata[g] = i_req_wdata[g*REG_DW +: REG_DW];
        assign w_wcrc[g]  = i_req_wcrc[g*REG_CRC_W +: REG_CRC_W];
    end

    // Grant pick: scan starts after the pointer (rr) or at index 0 (fixed).
    always_comb begin
        w_hit = 1'b0;
        w_gid = '0;
        w_idx = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            if (i_rr_en) begin
                w_idx = {1'b0, r_ptr} + (GID_W+1)'(k + 1);
                if (w_idx >= (GID_W+1)'(REQ_NUM)) begin
                    w_idx = w_idx - (GID_W+1)'(REQ_NUM);
                end
            end else begin
                w_idx = (GID_W+1)'(k);
            end
            if (!w_hit && i_req_vld[w_idx[GID_W-1:0]]) begin
                w_hit = 1'b1;
                w_gid = w_idx[GID_W-1:0];
            end
        end
    end

    // One-hot of the granted requester for ack/err.
    always_comb begin
        w_gid_oh = '0;
        w_gid_oh[r_gid] = 1'b1;
    end

    assign w_ack_ok = r_wr ? i_reg_rac_wack : i_reg_rac_rack;
    assign w_tmo    = (r_tmr == TW'(TMO_CYC - 1));

    // Access FSM; every output is a register updated here.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= GID_W'(REQ_NUM - 1);
            r_gid       <= '0;
            r_wr        <= 1'b0;
            r_tmr       <= '0;
            r_req_ack   <= '0;
            r_req_err   <= '0;
            r_rsp_rdata <= '0;
            r_rsp_rcrc  <= '0;
            r_rsp_addr  <= '0;
            r_busy      <= 1'b0;
            r_tmo_cnt   <= '0;
            r_ren       <= 1'b0;
            r_wen       <= 1'b0;
            r_rac_addr  <= '0;
            r_rac_wdata <= '0;
            r_rac_wcrc  <= '0;
        end else begin
            r_req_ack <= '0;
            r_req_err <= '0;
            r_ren     <= 1'b0;
            r_wen     <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_gid       <= w_gid;
                        r_ptr       <= w_gid;
                        r_wr        <= i_req_wr[w_gid];
                        r_rac_addr  <= w_addr[w_gid];
                        r_rac_wdata <= w_wdata[w_gid];
                        r_rac_wcrc  <= w_wcrc[w_gid];
                        r_ren       <= ~i_req_wr[w_gid];
                        r_wen       <= i_req_wr[w_gid];
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_tmr   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_ack_ok) begin
                        r_rsp_addr  <= r_rac_addr;
                        r_rsp_rdata <= r_wr ? r_rac_wdata : i_reg_rac_rdata;
                        r_rsp_rcrc  <= r_wr ? r_rac_wcrc : i_reg_rac_rcrc;
                        r_req_ack   <= w_gid_oh;
                        r_state     <= S_RESP;
                    end else if (w_tmo) begin
                        r_rsp_addr  <= r_rac_addr;
                        r_rsp_rdata <= '0;
                        r_rsp_rcrc  <= '0;
                        r_req_ack   <= w_gid_oh;
                        r_req_err   <= w_gid_oh;
                        if (r_tmo_cnt != 8'hFF) begin
                            r_tmo_cnt <= r_tmo_cnt + 8'd1;
                        end
                        r_state     <= S_RESP;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                S_RESP: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
            if (i_tmo_cnt_clr) begin
                r_tmo_cnt <= '0;
            end
        end
    end

    assign o_req_ack       = r_req_ack;
    assign o_req_err       = r_req_err;
    assign o_rsp_rdata     = r_rsp_rdata;
    assign o_rsp_rcrc      = r_rsp_rcrc;
    assign o_rsp_addr      = r_rsp_addr;
    assign o_busy          = r_busy;
    assign o_tmo_cnt       = r_tmo_cnt;
    assign o_rac_reg_ren   = r_ren;
    assign o_rac_reg_wen   = r_wen;
    assign o_rac_reg_addr  = r_rac_addr;
    assign o_rac_reg_wdata = r_rac_wdata;
    assign o_rac_reg_wcrc  = r_rac_wcrc;

endmodule
